// File: rtl/pll_md_reconfig_if.sv
// Handshake, PLL control and Gowin MD-port signals of the PLL reprogramming sequencer.
// The slave modport is the sequencer; the master modport is the requester and PLL side.
interface pll_md_reconfig_if;
   logic       req;
   logic       prof_sel;
   logic       busy;
   logic       done;
   logic       error;
   logic       pll_reset;
   logic       pll_lock;
   logic       mdclk;
   logic [1:0] mdopc;
   logic       mdainc;
   logic [7:0] mdwdi;
   logic [7:0] mdrdo;

   modport slave (
      input  req, prof_sel, pll_lock, mdrdo,
      output busy, done, error, pll_reset, mdclk, mdopc, mdainc, mdwdi
   );

   modport master (
      output req, prof_sel, pll_lock, mdrdo,
      input  busy, done, error, pll_reset, mdclk, mdopc, mdainc, mdwdi
   );
endinterface

// File: rtl/pll_md_reconfig.sv
// Gowin PLLA MD-port sequencer: holds the PLL in reset and writes IDIV/MDIV/ODIV0 for one of two
// profiles, then waits for lock with retry. PLL_MD_READBACK_EN adds a read-back verify pass.
module pll_md_reconfig #(
   parameter logic [7:0]  ADDR_IDIV    = 8'h00,
   parameter logic [7:0]  ADDR_MDIV    = 8'h01,
   parameter logic [7:0]  ADDR_ODIV0   = 8'h02,
   parameter logic [7:0]  P0_IDIV      = 8'd1,
   parameter logic [7:0]  P0_MDIV      = 8'd27,
   parameter logic [7:0]  P0_ODIV0     = 8'd50,
   parameter logic [7:0]  P1_IDIV      = 8'd1,
   parameter logic [7:0]  P1_MDIV      = 8'd28,
   parameter logic [7:0]  P1_ODIV0     = 8'd50,
   parameter int unsigned RST_HOLD     = 16,
   parameter int unsigned LOCK_TIMEOUT = 200000,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic                clk,
   input  logic                reset,
   pll_md_reconfig_if.slave    io_md
);
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned CNT_W = $clog2(RST_HOLD + 4);
   localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_LA  = 2'b11;

   typedef enum logic [3:0] {
      StIdle,
      StAssertRst,
      StAddr,
      StWrite,
      StGap,
      StHold,
      StWaitLock,
      StFail
`ifdef PLL_MD_READBACK_EN
      , StVerify
`endif
   } state_t;

   state_t             r_state;
   logic               r_phase;
   logic [1:0]         r_idx;
   logic [CNT_W-1:0]   r_cnt;
   logic [TMO_W-1:0]   r_tmo;
   logic [2:0]         r_lcnt;
   logic [RTY_W-1:0]   r_retry;
   logic               r_prof;
   logic               r_lock_s1;
   logic               r_lock_s2;
   logic               r_busy;
   logic               r_done;
   logic               r_error;
   logic               r_pll_reset;
   logic               r_mdclk;
   logic [1:0]         r_mdopc;
   logic [7:0]         r_mdwdi;
`ifdef PLL_MD_READBACK_EN
   logic [1:0]         r_vstep;
`endif

   logic [1:0]         w_idx_nxt;
   logic               w_last;
   logic               w_tmo_hit;
   logic               w_locked;

   function automatic logic [7:0] f_addr(input logic [1:0] idx);
      logic [7:0] a;
      case (idx)
         2'd0:    a = ADDR_IDIV;
         2'd1:    a = ADDR_MDIV;
         default: a = ADDR_ODIV0;
      endcase
      return a;
   endfunction

   function automatic logic [7:0] f_val(input logic prof, input logic [1:0] idx);
      logic [7:0] v;
      case (idx)
         2'd0:    v = prof ? P1_IDIV : P0_IDIV;
         2'd1:    v = prof ? P1_MDIV : P0_MDIV;
         default: v = prof ? P1_ODIV0 : P0_ODIV0;
      endcase
      return v;
   endfunction

   assign w_idx_nxt = r_idx + 2'd1;
   assign w_last    = (r_idx == 2'd2);
   assign w_tmo_hit = (r_tmo == TMO_W'(LOCK_TIMEOUT));
   // Eighth consecutive synchronised-high sample completes the qualification window.
   assign w_locked  = r_lock_s2 && (r_lcnt == 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock_s1 <= 1'b0;
         r_lock_s2 <= 1'b0;
      end else begin
         r_lock_s1 <= io_md.pll_lock;
         r_lock_s2 <= r_lock_s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_phase     <= 1'b0;
         r_idx       <= 2'd0;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_lcnt      <= 3'd0;
         r_retry     <= '0;
         r_prof      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_pll_reset <= 1'b0;
         r_mdclk     <= 1'b0;
         r_mdopc     <= OP_NOP;
         r_mdwdi     <= 8'h00;
`ifdef PLL_MD_READBACK_EN
         r_vstep     <= 2'd0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (io_md.req) begin
                  r_prof      <= io_md.prof_sel;
                  r_busy      <= 1'b1;
                  r_error     <= 1'b0;
                  r_retry     <= '0;
                  r_pll_reset <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= StAssertRst;
               end
            end
            StAssertRst: begin
               if (r_cnt == CNT_W'(3)) begin
                  r_idx   <= 2'd0;
                  r_phase <= 1'b0;
                  r_mdclk <= 1'b0;
                  r_mdopc <= OP_LA;
                  r_mdwdi <= f_addr(2'd0);
                  r_state <= StAddr;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            // Each op is phase A (mdclk low, opc/wdi change) then phase B (mdclk high).
            StAddr: begin
               if (!r_phase) begin
                  r_phase <= 1'b1;
                  r_mdclk <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  r_mdclk <= 1'b0;
                  r_mdopc <= OP_WR;
                  r_mdwdi <= f_val(r_prof, r_idx);
                  r_state <= StWrite;
               end
            end
            StWrite: begin
               if (!r_phase) begin
                  r_phase <= 1'b1;
                  r_mdclk <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  r_mdclk <= 1'b0;
                  r_mdopc <= OP_NOP;
                  r_state <= StGap;
               end
            end
            StGap: begin
               if (!r_phase) begin
                  r_phase <= 1'b1;
                  r_mdclk <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  r_mdclk <= 1'b0;
                  if (w_last) begin
`ifdef PLL_MD_READBACK_EN
                     r_idx   <= 2'd0;
                     r_vstep <= 2'd0;
                     r_mdopc <= OP_LA;
                     r_mdwdi <= f_addr(2'd0);
                     r_state <= StVerify;
`else
                     r_cnt   <= '0;
                     r_state <= StHold;
`endif
                  end else begin
                     r_idx   <= w_idx_nxt;
                     r_mdopc <= OP_LA;
                     r_mdwdi <= f_addr(w_idx_nxt);
                     r_state <= StAddr;
                  end
               end
            end
`ifdef PLL_MD_READBACK_EN
            // Load address, read, then sample mdrdo as the following nop slot ends.
            StVerify: begin
               if (!r_phase) begin
                  r_phase <= 1'b1;
                  r_mdclk <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  r_mdclk <= 1'b0;
                  case (r_vstep)
                     2'd0: begin
                        r_mdopc <= OP_RD;
                        r_vstep <= 2'd1;
                     end
                     2'd1: begin
                        r_mdopc <= OP_NOP;
                        r_vstep <= 2'd2;
                     end
                     default: begin
                        if (io_md.mdrdo != f_val(r_prof, r_idx)) begin
                           r_error     <= 1'b1;
                           r_busy      <= 1'b0;
                           r_pll_reset <= 1'b0;
                           r_state     <= StFail;
                        end else if (w_last) begin
                           r_cnt   <= '0;
                           r_state <= StHold;
                        end else begin
                           r_idx   <= w_idx_nxt;
                           r_vstep <= 2'd0;
                           r_mdopc <= OP_LA;
                           r_mdwdi <= f_addr(w_idx_nxt);
                        end
                     end
                  endcase
               end
            end
`endif
            StHold: begin
               if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
                  r_pll_reset <= 1'b0;
                  r_tmo       <= '0;
                  r_lcnt      <= 3'd0;
                  r_state     <= StWaitLock;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            StWaitLock: begin
               if (w_locked) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else begin
                  // A lock drop restarts qualification but not the timeout.
                  r_lcnt <= r_lock_s2 ? r_lcnt + 3'd1 : 3'd0;
                  if (w_tmo_hit) begin
                     if (r_retry < RTY_W'(MAX_RETRY - 1)) begin
                        r_retry     <= r_retry + RTY_W'(1);
                        r_pll_reset <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= StAssertRst;
                     end else begin
                        r_error     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_pll_reset <= 1'b0;
                        r_state     <= StFail;
                     end
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end
            end
            StFail: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_md.busy      = r_busy;
   assign io_md.done      = r_done;
   assign io_md.error     = r_error;
   assign io_md.pll_reset = r_pll_reset;
   assign io_md.mdclk     = r_mdclk;
   assign io_md.mdopc     = r_mdopc;
   assign io_md.mdainc    = 1'b0;
   assign io_md.mdwdi     = r_mdwdi;
endmodule

// File: tb/tb_pll_md_reconfig.sv
// Randomised bench for pll_md_reconfig: a PLL/lock model plus an expected MD op trace built
// from the profile tables; outcome, trace, retry count and done timing are checked.
`timescale 1ns/1ps
module tb_pll_md_reconfig;
   localparam int unsigned TMO = 1000;
   localparam int unsigned MAX_RETRY = 3;
`ifdef PLL_MD_READBACK_EN
   localparam bit RB = 1'b1;
   localparam int NV = 3;
`else
   localparam bit RB = 1'b0;
   localparam int NV = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   pll_md_reconfig_if u_if();

   pll_md_reconfig #(
      .LOCK_TIMEOUT(TMO),
      .MAX_RETRY   (MAX_RETRY)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .io_md(u_if)
   );

   always #10 clk = ~clk;

   logic [7:0] addr_t [3] = '{8'h00, 8'h01, 8'h02};
   logic [7:0] val_t [2][3] = '{'{8'd1, 8'd27, 8'd50}, '{8'd1, 8'd28, 8'd50}};

   int n_chk = 0;
   int n_fail = 0;

   int fails = 0;
   int delay = 20;
   bit glitch = 1'b0;
   bit corrupt = 1'b0;
   int att = 0;
   int lk_cnt = 0;
   logic lk_prev = 1'b0;
   int done_cnt = 0;
   int done_at = 0;
   logic [9:0] trace [$];
   logic [9:0] exp_q [$];
   logic [7:0] pll_regs [4];
   logic [7:0] ra = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Lock model: attempts numbered by pll_reset rising edges; first 'fails' attempts never lock.
   initial begin
      u_if.pll_lock = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (u_if.pll_reset && !lk_prev) att++;
         lk_prev = u_if.pll_reset;
         if (u_if.pll_reset || att <= fails) begin
            lk_cnt = 0;
            u_if.pll_lock = 1'b0;
         end else begin
            lk_cnt++;
            if (glitch)
               u_if.pll_lock = (lk_cnt > delay && lk_cnt <= delay + 5) || lk_cnt > delay + 6;
            else
               u_if.pll_lock = lk_cnt > delay;
         end
      end
   end

   // PLL MD register file; optionally corrupts the MDIV read-back.
   initial begin
      u_if.mdrdo = 8'h00;
      forever begin
         @(posedge u_if.mdclk);
         #1;
         case (u_if.mdopc)
            2'b11: ra = u_if.mdwdi;
            2'b01: pll_regs[ra[1:0]] = u_if.mdwdi;
            2'b10: u_if.mdrdo = (corrupt && ra == 8'h01) ? 8'h1B : pll_regs[ra[1:0]];
            default: ;
         endcase
      end
   end

   initial begin
      forever begin
         @(posedge u_if.mdclk);
         if (u_if.mdopc == 2'b00 || u_if.mdopc == 2'b10) trace.push_back({u_if.mdopc, 8'h00});
         else trace.push_back({u_if.mdopc, u_if.mdwdi});
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (u_if.done === 1'b1) begin
            done_cnt++;
            done_at = lk_cnt;
         end
      end
   end

   task automatic exp_attempt(input bit p, input int n_verify);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({2'b11, addr_t[i]});
         exp_q.push_back({2'b01, val_t[p][i]});
         exp_q.push_back(10'h000);
      end
      for (int i = 0; i < n_verify; i++) begin
         exp_q.push_back({2'b11, addr_t[i]});
         exp_q.push_back({2'b10, 8'h00});
         exp_q.push_back(10'h000);
      end
   endtask

   task automatic run_txn(input bit p, input int nfail, input int dly, input bit gl, input bit xreq,
                          input bit corr, input string nm);
      int cyc;
      int exp_att;
      bit exp_ok;
      int lo;
      int n;
      fails = nfail;
      delay = dly;
      glitch = gl;
      corrupt = corr;
      @(negedge clk);
      trace.delete();
      exp_q.delete();
      done_cnt = 0;
      att = 0;
      u_if.prof_sel = p;
      u_if.req = 1'b1;
      @(negedge clk);
      u_if.req = 1'b0;
      u_if.prof_sel = ~p;
      chk({nm, "_busy_set"}, {31'd0, u_if.busy}, 32'd1);
      chk({nm, "_err_clr"}, {31'd0, u_if.error}, 32'd0);
      cyc = 0;
      while (u_if.busy === 1'b1 && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         u_if.req = (xreq && cyc == 40);
      end
      u_if.req = 1'b0;
      chk({nm, "_finished"}, {31'd0, cyc < 8000}, 32'd1);
      repeat (3) @(negedge clk);

      if (RB && corr && p) begin
         exp_ok = 1'b0;
         exp_att = 1;
         exp_attempt(p, 2);
      end else begin
         exp_ok = (nfail < MAX_RETRY);
         exp_att = exp_ok ? nfail + 1 : MAX_RETRY;
         for (int a = 0; a < exp_att; a++) exp_attempt(p, NV);
         if (!exp_ok) chk({nm, "_fail_late"}, {31'd0, cyc >= 3 * TMO}, 32'd1);
      end

      chk({nm, "_done_cnt"}, done_cnt, exp_ok ? 32'd1 : 32'd0);
      chk({nm, "_error"}, {31'd0, u_if.error}, exp_ok ? 32'd0 : 32'd1);
      chk({nm, "_busy_end"}, {31'd0, u_if.busy}, 32'd0);
      chk({nm, "_pll_rst_end"}, {31'd0, u_if.pll_reset}, 32'd0);
      chk({nm, "_attempts"}, att, exp_att);
      chk({nm, "_trace_len"}, trace.size(), exp_q.size());
      chk({nm, "_mdainc"}, {31'd0, u_if.mdainc}, 32'd0);
      n = (trace.size() < exp_q.size()) ? trace.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_md%0d", nm, i), {22'd0, trace[i]},
                                      {22'd0, exp_q[i]});
      if (exp_ok) begin
         lo = gl ? dly + 14 : dly + 8;
         chk({nm, "_done_time"}, {31'd0, done_at >= lo && done_at <= lo + 6}, 32'd1);
      end
   endtask

   initial begin
      int cyc;
      u_if.req = 1'b0;
      u_if.prof_sel = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
      chk("rst_done", {31'd0, u_if.done}, 32'd0);
      chk("rst_error", {31'd0, u_if.error}, 32'd0);
      chk("rst_pll_reset", {31'd0, u_if.pll_reset}, 32'd0);
      chk("rst_mdclk", {31'd0, u_if.mdclk}, 32'd0);
      chk("rst_mdopc", {30'd0, u_if.mdopc}, 32'd0);
      chk("rst_mdwdi", {24'd0, u_if.mdwdi}, 32'd0);
      chk("rst_mdainc", {31'd0, u_if.mdainc}, 32'd0);

      run_txn(1'b1, 0, 100, 1'b0, 1'b0, 1'b0, "basic");
      run_txn(1'b0, 3, 50, 1'b0, 1'b0, 1'b0, "timeout");
      run_txn(1'b1, 1, 60, 1'b0, 1'b0, 1'b0, "retry");
      run_txn(1'b0, 0, 30, 1'b1, 1'b1, 1'b0, "glitch");

      // Async reset while MDIV of profile 0 is being written.
      fails = 0;
      glitch = 1'b0;
      @(negedge clk);
      u_if.prof_sel = 1'b0;
      u_if.req = 1'b1;
      @(negedge clk);
      u_if.req = 1'b0;
      cyc = 0;
      while (!(u_if.mdopc === 2'b01 && u_if.mdwdi === 8'd27) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("ar_reach_mdiv", {31'd0, cyc < 200}, 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("ar_mdopc", {30'd0, u_if.mdopc}, 32'd0);
      chk("ar_pll_reset", {31'd0, u_if.pll_reset}, 32'd0);
      chk("ar_busy", {31'd0, u_if.busy}, 32'd0);
      chk("ar_mdclk", {31'd0, u_if.mdclk}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_txn(1'b1, 0, 25, 1'b0, 1'b0, 1'b0, "after_ar");

      if (RB) run_txn(1'b1, 0, 40, 1'b0, 1'b0, 1'b1, "rb_bad");

      for (int k = 0; k < 6; k++)
         run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(10, 150)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", k));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
